// File: rtl/mag_comp_min_sched_pkg.sv
// Shared definitions for the frame-minimum scheduler: sample width and FSM encoding.
package mag_comp_min_sched_pkg;

  localparam int SAMPLE_W = 3;

  typedef logic [SAMPLE_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mag_comp_min_sched_if.sv
// Sample-in / result-out handshake bundle for mag_comp_min_sched.
interface mag_comp_min_sched_if #(
  parameter int IDX_W = 3
);
  import mag_comp_min_sched_pkg::*;

  logic             clr;
  logic             in_valid;
  logic             in_ready;
  sample_t          in_data;
  logic             out_valid;
  logic             out_ready;
  sample_t          out_min;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output clr, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_min, out_idx
  );

  modport slave (
    input  clr, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_min, out_idx
  );

endinterface

// File: rtl/mag_comp_CLA_3bit_comb.sv
// 3-bit unsigned magnitude comparator: cp = (in_a > in_b), lookahead form.
module mag_comp_CLA_3bit_comb
  import mag_comp_min_sched_pkg::*;
(
  input  sample_t in_a,
  input  sample_t in_b,
  output logic    cp
);

  logic [SAMPLE_W-1:0] g;
  logic [SAMPLE_W-1:0] e;

  // Per-bit "a wins" and "bits equal" terms, resolved from the MSB down.
  assign g  = in_a & ~in_b;
  assign e  = ~(in_a ^ in_b);
  assign cp = g[2] | (e[2] & g[1]) | (e[2] & e[1] & g[0]);

endmodule

// File: rtl/mag_comp_min_sched.sv
// Tracks the minimum sample of a FRAME_LEN-sample frame and its first index.
module mag_comp_min_sched
  import mag_comp_min_sched_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int IDX_W     = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  mag_comp_min_sched_if.slave bus
);

  if (IDX_W != $clog2(FRAME_LEN)) begin : g_bad_idx_w
    $error("IDX_W must equal clog2(FRAME_LEN)");
  end

  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(FRAME_LEN - 1);

  state_t           state, state_nxt;
  sample_t          min_reg, min_nxt;
  logic [IDX_W-1:0] idx_reg, idx_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;
  logic             accept;
  logic             cp;

  mag_comp_CLA_3bit_comb u_cmp (
    .in_a (min_reg),
    .in_b (bus.in_data),
    .cp   (cp)
  );

  assign accept = bus.in_valid && (state != DONE);

  always_comb begin
    // NOTE: every output gets a default first, so no branch can infer a latch.
    state_nxt = state;
    min_nxt   = min_reg;
    idx_nxt   = idx_reg;
    cnt_nxt   = cnt;
    if (bus.clr) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          min_nxt   = bus.in_data;
          idx_nxt   = '0;
          cnt_nxt   = IDX_W'(1);
          state_nxt = ACCUM;
        end
        ACCUM: if (accept) begin
          // Strict less-than: a tie keeps the earlier index.
          if (cp) begin
            min_nxt = bus.in_data;
            idx_nxt = cnt;
          end
          if (cnt == LAST_CNT) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + IDX_W'(1);
          end
        end
        DONE: if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      min_reg <= SAMPLE_MAX;
      idx_reg <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      min_reg <= min_nxt;
      idx_reg <= idx_nxt;
      cnt     <= cnt_nxt;
    end
  end

  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_min   = min_reg;
  assign bus.out_idx   = idx_reg;

endmodule

// File: tb/tb_mag_comp_min_sched.sv
// Scoreboard bench: a frame model queues expected results, a monitor compares them.
module tb_mag_comp_min_sched;
  import mag_comp_min_sched_pkg::*;

  typedef struct {
    int mn;
    int mi;
  } res_t;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       s_sel   = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_clr   = 1'b0;
  logic       s_ready = 1'b1;
  logic [2:0] s_data  = '0;

  int   checks = 0;
  int   errors = 0;
  int   smp[$];
  int   mq[$];
  int   iq[$];
  int   fr[$];
  res_t exp_q[$];
  res_t r;
  res_t drop;
  bit   pending = 1'b0;
  int   flen;

  always #5 clk = ~clk;

  mag_comp_min_sched_if #(.IDX_W(3)) bus8 ();
  mag_comp_min_sched_if #(.IDX_W(3)) bus5 ();

  assign bus8.in_valid  = s_valid & ~s_sel;
  assign bus8.in_data   = s_data;
  assign bus8.clr       = s_clr & ~s_sel;
  assign bus8.out_ready = s_ready & ~s_sel;
  assign bus5.in_valid  = s_valid & s_sel;
  assign bus5.in_data   = s_data;
  assign bus5.clr       = s_clr & s_sel;
  assign bus5.out_ready = s_ready & s_sel;

  mag_comp_min_sched #(.FRAME_LEN(8), .IDX_W(3)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  mag_comp_min_sched #(.FRAME_LEN(5), .IDX_W(3)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  logic       m_in_ready, m_out_valid;
  logic [2:0] m_out_min, m_out_idx;
  assign m_in_ready  = s_sel ? bus5.in_ready  : bus8.in_ready;
  assign m_out_valid = s_sel ? bus5.out_valid : bus8.out_valid;
  assign m_out_min   = s_sel ? bus5.out_min   : bus8.out_min;
  assign m_out_idx   = s_sel ? bus5.out_idx   : bus8.out_idx;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: collect accepted samples, emit min and first index when the frame fills.
  always @(posedge clk or negedge rst_n) begin
    flen = s_sel ? 5 : 8;
    if (!rst_n) begin
      smp.delete();
      if (pending) drop = exp_q.pop_front();
      pending = 1'b0;
    end else if (s_clr) begin
      smp.delete();
      if (pending) drop = exp_q.pop_front();
      pending = 1'b0;
    end else if (pending) begin
      if (s_ready) pending = 1'b0;
    end else if (s_valid) begin
      smp.push_back(int'(s_data));
      if (smp.size() == flen) begin
        mq   = smp.min();
        r.mn = mq[0];
        iq   = smp.find_first_index(x) with (x == r.mn);
        r.mi = iq[0];
        exp_q.push_back(r);
        pending = 1'b1;
        smp.delete();
      end
    end
  end

  // Monitor: compare every presented result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", int'(m_in_ready), int'(!pending));
      check("out_valid", int'(m_out_valid), int'(pending));
      if (m_out_valid && pending && exp_q.size() > 0) begin
        check("out_min", int'(m_out_min), exp_q[0].mn);
        check("out_idx", int'(m_out_idx), exp_q[0].mi);
        if (s_ready && !s_clr) drop = exp_q.pop_front();
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int vals[$], input int pct, input bit rnd_ready);
    int k = 0;
    int guard = 0;
    bit will;
    while (k < vals.size() && guard < 2000) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = 3'(vals[k]);
      if (rnd_ready) s_ready = 1'($urandom_range(1));
      will = s_valid && !pending && !s_clr;
      step(1);
      if (will) k++;
      guard++;
    end
    s_valid = 1'b0;
    if (k != vals.size()) check("frame_timeout", k, vals.size());
  endtask

  task automatic rand_frames(input int n, input int len);
    for (int f = 0; f < n; f++) begin
      fr.delete();
      for (int i = 0; i < len; i++) fr.push_back(int'($urandom_range(7)));
      drive_frame(fr, int'($urandom_range(30, 100)), 1'b1);
    end
    s_ready = 1'b1;
    step(3);
  endtask

  task automatic check_result(input string tag, input int mn, input int mi);
    check({tag, "_valid"}, int'(m_out_valid), 1);
    check({tag, "_min"}, int'(m_out_min), mn);
    check({tag, "_idx"}, int'(m_out_idx), mi);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", int'(bus8.in_ready), 1);
    check("rst_out_valid", int'(bus8.out_valid), 0);
    check("rst_out_min", int'(bus8.out_min), 7);
    check("rst_out_idx", int'(bus8.out_idx), 0);
    check("rst5_out_min", int'(bus5.out_min), 7);
    @(negedge clk);
    rst_n = 1'b1;
    step(2);

    fr = '{5, 3, 6, 3, 7, 1, 4, 2};
    drive_frame(fr, 100, 1'b0);
    check_result("basic", 1, 5);
    step(2);

    fr = '{4, 2, 2, 5, 2, 6, 7, 3};
    drive_frame(fr, 100, 1'b0);
    check_result("ties", 2, 1);
    step(2);

    s_ready = 1'b0;
    fr = '{6, 6, 3, 5, 3, 7, 4, 6};
    drive_frame(fr, 100, 1'b0);
    repeat (5) begin
      s_valid = 1'b1;
      s_data  = 3'($urandom_range(7));
      step(1);
      check_result("bp_hold", 3, 2);
      check("bp_in_ready", int'(m_in_ready), 0);
    end
    s_valid = 1'b0;
    s_ready = 1'b1;
    fr = '{7, 5, 1, 1, 6, 0, 2, 0};
    drive_frame(fr, 100, 1'b0);
    check_result("after_bp", 0, 5);
    step(2);

    fr = '{0, 7, 7, 7, 7, 7, 7, 7};
    drive_frame(fr, 50, 1'b0);
    check_result("bubble_zero", 0, 0);
    fr = '{7, 7, 7, 7, 7, 7, 7, 7};
    drive_frame(fr, 50, 1'b0);
    check_result("bubble_sevens", 7, 0);
    step(2);

    fr = '{1, 2, 3, 4};
    drive_frame(fr, 100, 1'b0);
    s_clr   = 1'b1;
    s_valid = 1'b1;
    s_data  = 3'd0;
    step(1);
    s_clr   = 1'b0;
    s_valid = 1'b0;
    check("clr_in_ready", int'(m_in_ready), 1);
    fr = '{6, 5, 4, 3, 2, 1, 0, 7};
    drive_frame(fr, 100, 1'b0);
    check_result("after_clr", 0, 6);
    step(2);

    s_ready = 1'b0;
    fr = '{3, 3, 3, 3, 3, 3, 3, 3};
    drive_frame(fr, 100, 1'b0);
    s_clr = 1'b1;
    step(1);
    s_clr   = 1'b0;
    s_ready = 1'b1;
    check("clr_done_valid", int'(m_out_valid), 0);
    step(1);

    rand_frames(12, 8);

    fr = '{2, 0, 5};
    drive_frame(fr, 100, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("amid_rst_valid", int'(bus8.out_valid), 0);
    check("amid_rst_min", int'(bus8.out_min), 7);
    check("amid_rst_ready", int'(bus8.in_ready), 1);
    s_sel = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    fr = '{3, 1, 4, 1, 5};
    drive_frame(fr, 100, 1'b0);
    check_result("len5", 1, 1);
    step(2);

    rand_frames(12, 5);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mag_comp_min_sched.md
MAG_COMP_MIN_SCHED -- requirements
Module: mag_comp_min_sched

Interface
REQ-001 Parameter: FRAME_LEN, default 8, number of 3-bit samples per frame; legal range 2..256.
REQ-002 Parameter: IDX_W, default 3, index width; SHALL equal ceil(log2(FRAME_LEN)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous frame abort, active-high.
REQ-006 in_valid  input  1  sample present on in_data.
REQ-007 in_ready  output  1  block can accept a sample this cycle.
REQ-008 in_data  input  3  unsigned sample.
REQ-009 out_valid  output  1  frame result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_min  output  3  minimum sample of frame.
REQ-012 out_idx  output  IDX_W  position (0-based) of first occurrence of minimum.

Function
REQ-013 FSM states: IDLE, ACCUM, DONE; reset state IDLE.
REQ-014 Sample accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-015 in_ready=1 in IDLE and ACCUM, 0 in DONE.
REQ-016 IDLE + accept: min_reg<=in_data, idx_reg<=0, cnt<=1, go ACCUM.
REQ-017 ACCUM + accept: the comparator is fed in_a=min_reg, in_b=in_data; if cp=1 (in_data < min_reg) then min_reg<=in_data, idx_reg<=cnt; else both hold.
REQ-018 Ties SHALL keep the earlier index (strict less-than only).
REQ-019 cnt increments per accept; the accept with cnt=FRAME_LEN-1 is last: go DONE, cnt<=0.
REQ-020 ACCUM with no accept holds all state (bubbles allowed, unbounded).
REQ-021 out_valid=1 exactly in DONE; out_min=min_reg, out_idx=idx_reg, stable while out_ready=0.
REQ-022 Latency: out_valid asserts the cycle after the last sample is accepted.
REQ-023 DONE + out_ready=1: go IDLE next cycle; no same-cycle accept of next frame (one-cycle gap minimum).
REQ-024 clr=1 in any state: go IDLE, cnt<=0, out_valid deasserts next cycle; sample presented that cycle is discarded; clr has priority over accept and output handshake.
REQ-025 out_min/out_idx outside DONE: drive registered values (don't-care for consumer, but deterministic).
REQ-026 cnt width IDX_W+1 internally is not required; cnt SHALL never exceed FRAME_LEN-1 and never wrap past it.
REQ-027 FRAME_LEN a power of two and non-power of two SHALL both work.

Reset
REQ-028 rst_n=0 asynchronously forces: state IDLE, cnt=0, min_reg=3'b111, idx_reg=0.
REQ-029 Outputs during/after reset until first frame: in_ready=1, out_valid=0, out_min=3'b111, out_idx=0.
REQ-030 Reset mid-frame discards partial frame; no result emitted.

Structure
REQ-031 Shared package/include: FSM state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and sample width constant (3).
REQ-032 One sub-module: existing combinational comparator mag_comp_CLA_3bit_comb, instantiated once; no other comparison logic.
REQ-033 No combinational path from in_valid/out_ready to any output other than none; all outputs registered or state-decoded.

Verification
REQ-034 FRAME_LEN=8, samples 5,3,6,3,7,1,4,2 back-to-back -> out_min=1, out_idx=5, out_valid 1 cycle after 8th accept.
REQ-035 Ties: 4,2,2,5,2,6,7,3 -> out_min=2, out_idx=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; frame 2 starts after release + 1 cycle.
REQ-037 Bubbles: in_valid random 50% on 0,7,7,7,7,7,7,7 -> out_min=0, out_idx=0; all 7s -> out_min=7, out_idx=0.
REQ-038 clr after 4 accepts, then fresh frame 6,5,4,3,2,1,0,7 -> out_min=0, out_idx=6; no result from aborted frame.
REQ-039 rst_n low mid-frame (asynchronous, off clock edge) -> state IDLE, out_valid=0, out_min=7 immediately; FRAME_LEN=5 rerun 3,1,4,1,5 -> out_min=1, out_idx=1.
